// File: rtl/switch_bank.sv
// rtl/switch_bank.sv - multi-channel debounced switch bank with edge, long-press and auto-repeat strobes
module switch_bank #(
    parameter int N               = 5,
    parameter int DEBOUNCE_CYCLES = 240000,
    parameter int LONG_CYCLES     = 120000000,
    parameter int REPEAT_CYCLES   = 24000000
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic [N-1:0] sw,
    input  logic [N-1:0] rpt_en,
    output logic [N-1:0] d,
    output logic [N-1:0] pos,
    output logic [N-1:0] neg,
    output logic [N-1:0] long,
    output logic [N-1:0] rpt,
    output logic [N-1:0] held
);

    localparam int DCW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HCW = $clog2(LONG_CYCLES + 1);
    localparam int RCW = $clog2(REPEAT_CYCLES + 1);

    localparam logic [DCW-1:0] DC_LAST = DCW'(DEBOUNCE_CYCLES - 1);
    localparam logic [DCW-1:0] DC_ONE  = DCW'(1);
    localparam logic [HCW-1:0] HC_LAST = HCW'(LONG_CYCLES - 1);
    localparam logic [HCW-1:0] HC_MAX  = HCW'(LONG_CYCLES);
    localparam logic [HCW-1:0] HC_ONE  = HCW'(1);
    localparam logic [RCW-1:0] RC_LAST = RCW'(REPEAT_CYCLES - 1);
    localparam logic [RCW-1:0] RC_ONE  = RCW'(1);

    logic [N-1:0] s1_q, s1_d, s2_q, s2_d;
    logic [N-1:0] d_q, d_d, pos_q, pos_d, neg_q, neg_d;
    logic [N-1:0] long_q, long_d, rpt_q, rpt_d, held_q, held_d;
    logic [DCW-1:0] dc_q [N];
    logic [DCW-1:0] dc_d [N];
    logic [HCW-1:0] hc_q [N];
    logic [HCW-1:0] hc_d [N];
    logic [RCW-1:0] rc_q [N];
    logic [RCW-1:0] rc_d [N];

    always_comb begin
        s1_d   = sw;
        s2_d   = s1_q;
        d_d    = d_q;
        pos_d  = '0;
        neg_d  = '0;
        long_d = '0;
        rpt_d  = '0;
        held_d = held_q;
        dc_d   = dc_q;
        hc_d   = hc_q;
        rc_d   = rc_q;
        for (int i = 0; i < N; i++) begin
            if (s2_q[i] == d_q[i]) begin
                dc_d[i] = '0;
            end else if (dc_q[i] == DC_LAST) begin
                dc_d[i]  = '0;
                d_d[i]   = s2_q[i];
                pos_d[i] = s2_q[i];
                neg_d[i] = ~s2_q[i];
            end else begin
                dc_d[i] = dc_q[i] + DC_ONE;
            end

            // A release edge wins over any long/repeat strobe due on the same edge.
            if (!d_q[i] || neg_d[i]) begin
                hc_d[i]   = '0;
                rc_d[i]   = '0;
                held_d[i] = 1'b0;
            end else begin
                if (hc_q[i] != HC_MAX) begin
                    hc_d[i] = hc_q[i] + HC_ONE;
                end
                if (hc_q[i] == HC_LAST) begin
                    long_d[i] = 1'b1;
                    held_d[i] = 1'b1;
                    rc_d[i]   = '0;
                end else if (held_q[i]) begin
                    // Phase runs regardless of rpt_en so re-enabling keeps cadence.
                    if (rc_q[i] == RC_LAST) begin
                        rc_d[i]  = '0;
                        rpt_d[i] = rpt_en[i];
                    end else begin
                        rc_d[i] = rc_q[i] + RC_ONE;
                    end
                end
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            s1_q   <= '0;
            s2_q   <= '0;
            d_q    <= '0;
            pos_q  <= '0;
            neg_q  <= '0;
            long_q <= '0;
            rpt_q  <= '0;
            held_q <= '0;
            dc_q   <= '{default: '0};
            hc_q   <= '{default: '0};
            rc_q   <= '{default: '0};
        end else begin
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            d_q    <= d_d;
            pos_q  <= pos_d;
            neg_q  <= neg_d;
            long_q <= long_d;
            rpt_q  <= rpt_d;
            held_q <= held_d;
            dc_q   <= dc_d;
            hc_q   <= hc_d;
            rc_q   <= rc_d;
        end
    end

    assign d    = d_q;
    assign pos  = pos_q;
    assign neg  = neg_q;
    assign long = long_q;
    assign rpt  = rpt_q;
    assign held = held_q;

endmodule

// File: doc/switch_bank.md
Name: switch_bank

Overview:
- Multi-channel successor to the single-button `switch` edge detector, for all five buttons and/or the DIP bank.
- Per channel, in one clock domain (clk240 in the top level):
  - 2-flop synchronisation
  - counter-based debounce
  - rising/falling edge pulses
  - long-press detection
  - optional auto-repeat
- Outputs drive LCD UI logic (start, page, increment) directly as single-cycle strobes.

Parameters:
- N, 5, number of independent channels (≥1)
- DEBOUNCE_CYCLES, 240000, cycles the synchronised input must differ from `d` before `d` changes (≥1)
- LONG_CYCLES, 120000000, cycles after `pos` at which `long` fires (≥1)
- REPEAT_CYCLES, 24000000, interval between `rpt` pulses after `long` (≥1)

Ports:
- CLK  in  1  system clock
- RST  in  1  asynchronous, active-high reset
- sw  in  N  raw asynchronous switch inputs, active high
- rpt_en  in  N  per-channel auto-repeat enable, synchronous to CLK
- d  out  N  debounced level
- pos  out  N  1-cycle pulse on debounced rising edge
- neg  out  N  1-cycle pulse on debounced falling edge
- long  out  N  1-cycle pulse when held LONG_CYCLES after `pos`
- rpt  out  N  1-cycle auto-repeat pulses while held
- held  out  N  high from the `long` cycle until `d` falls

Behaviour:
- Reset: all state clears asynchronously on RST=1.
  - Synchronisers, counters, `d`, `pos`, `neg`, `long`, `rpt` and `held` all go to 0.
  - Operation resumes on the first CLK edge after RST falls.
- Channels are fully independent; no cross-channel interaction.
- Synchroniser: s1<=sw, s2<=s1.
- Debounce counter `dc`, width $clog2(DEBOUNCE_CYCLES+1):
  - If s2==d: dc<=0.
  - Else if dc==DEBOUNCE_CYCLES-1: d<=s2, dc<=0, pos<=s2, neg<=~s2.
  - Else: dc<=dc+1.
- `pos` and `neg` are registered and high for exactly one cycle.
- Latency: an input change stable from sampling edge E0 appears on `d`/`pos`/`neg` after edge E0+DEBOUNCE_CYCLES+1, i.e. DEBOUNCE_CYCLES+2 edges inclusive of E0.
- Glitch rejection boundary:
  - A pulse of DEBOUNCE_CYCLES-1 sampled cycles is ignored.
  - A pulse of exactly DEBOUNCE_CYCLES cycles is accepted.
- Hold counter `hc`, width $clog2(LONG_CYCLES+1):
  - Cleared when d==0 and on the `pos` edge.
  - Increments while d==1, saturating at LONG_CYCLES.
  - `long` pulses in the cycle exactly LONG_CYCLES cycles after the `pos` cycle; `held` sets in that same cycle.
- Repeat counter `rc`:
  - Starts at 0 in the `long` cycle.
  - Wraps at REPEAT_CYCLES-1.
  - `rpt` pulses at pos+LONG_CYCLES+k*REPEAT_CYCLES for k≥1, only while rpt_en[i]==1.
- rpt_en gates the output only; rc keeps running, so re-enabling mid-hold keeps the original phase.
- Release (d falls): `neg` pulses; hc, rc and `held` clear on the same edge.
  - If `long` or `rpt` would coincide with that edge, they are suppressed and only `neg` fires.
- Input high when RST falls: treated as a press, so `pos` fires after normal debounce latency.
- Reset asserted mid-debounce or mid-hold: state clears immediately with no pulses; the press is re-detected afterward if sw is still high.

Test Plan:
Bench parameters: N=2, DEBOUNCE_CYCLES=4, LONG_CYCLES=10, REPEAT_CYCLES=3. All counts in CLK cycles; sw changes between edges.
- Clean press: sw[0] 0→1 before edge E0 and held → d[0]=1 and pos[0]=1 for the one cycle after E5; neg, long, rpt stay 0 through E14.
- Glitch boundary: sw[0] high for 3 cycles → no pos, d stays 0. sw[0] high for exactly 4 cycles → pos at E5, then neg 4 cycles after the falling input is first sampled+2.
- Long press + repeat (rpt_en[0]=1, hold 25 cycles after pos):
  - long at pos+10, with held=1 from then on.
  - rpt at pos+13, +16, +19, +22.
  - On release: neg, held→0, no further rpt.
- Repeat gating: as the previous case with rpt_en[0]=0 during pos+12..pos+17 → rpt only at pos+19, +22; long unaffected.
- Coincident release: release timed so d falls on the pos+10 edge → neg only, long never asserted, held stays 0.
- Reset/independence:
  - Ch1 stimulus meanwhile produces no activity on ch0.
  - RST pulsed mid-debounce with sw[1] held high → all outputs 0 during RST; pos[1] fires 6 edges after RST release.
